// File: rtl/uart_pkg.sv
// Shared types and constants for the UART RX frame checker.
`timescale 1ns/1ps
package uart_pkg;

  // Legal data-field widths and bit counter width (max frame is 13 bits)
  localparam int DW_MIN   = 5;
  localparam int DW_MAX   = 9;
  localparam int BITCNT_W = 4;

  typedef enum logic [1:0] {
    PAR_EVEN  = 2'b00,
    PAR_ODD   = 2'b01,
    PAR_MARK  = 2'b10,
    PAR_SPACE = 2'b11
  } par_typ_e;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } state_e;

  // Parity bit the transmitter should have sent, given the running XOR of the data
  function automatic logic exp_parity(input par_typ_e typ, input logic run_par);
    case (typ)
      PAR_EVEN: return run_par;
      PAR_ODD:  return ~run_par;
      PAR_MARK: return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
`timescale 1ns/1ps
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  // Count up until all-ones, then hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_count <= '0;
    else if (i_clr)
      r_count <= '0;
    else if (i_inc && !(&r_count))
      r_count <= r_count + CNT_W'(1);
  end

  assign o_count = r_count;

endmodule

// File: rtl/uart_rx_frame_checker.sv
// Deserialises voted RX bits into a DATA_WIDTH word, checks parity and stop
// bits, and reports per-frame status plus saturating error counts.
`timescale 1ns/1ps
module uart_rx_frame_checker
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  bit_vld,
  input  logic                  sampled_bit,
  input  logic                  cfg_par_en,
  input  logic [1:0]            cfg_par_typ,
  input  logic                  cfg_stop2,
  input  logic                  cnt_clr,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  frame_done,
  output logic                  data_vld,
  output logic                  par_err,
  output logic                  stp_err,
  output logic [CNT_W-1:0]      par_err_cnt,
  output logic [CNT_W-1:0]      stp_err_cnt
);

  if ((DATA_WIDTH < DW_MIN) || (DATA_WIDTH > DW_MAX)) begin : g_bad_width
    $error("uart_rx_frame_checker: DATA_WIDTH out of range 5..9");
  end

  state_e                r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_p_data;
  logic [BITCNT_W-1:0]   r_bitcnt;
  logic                  r_run_par;
  logic                  r_par_flag;
  logic                  r_stp_flag;
  // Shadow copies of cfg_* so mid-frame config changes are ignored
  logic                  r_par_en;
  par_typ_e              r_par_typ;
  logic                  r_stop2;
  logic                  r_busy;
  logic                  r_frame_done;
  logic                  r_data_vld;
  logic                  r_par_err;
  logic                  r_stp_err;

  logic w_last_data;
  logic w_finish;
  logic w_stp_final;

  assign w_last_data = (r_bitcnt == BITCNT_W'(DATA_WIDTH - 1));
  // frame_start pre-empts a bit strobe in the same cycle, so it also blocks finishing
  assign w_finish    = bit_vld && !frame_start &&
                       (((r_state == STOP1) && !r_stop2) || (r_state == STOP2));
  assign w_stp_final = r_stp_flag | ~sampled_bit;

  // Frame FSM: deserialise, accumulate error flags, emit one-cycle status on finish
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_p_data     <= '0;
      r_bitcnt     <= '0;
      r_run_par    <= 1'b0;
      r_par_flag   <= 1'b0;
      r_stp_flag   <= 1'b0;
      r_par_en     <= 1'b0;
      r_par_typ    <= PAR_EVEN;
      r_stop2      <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_data_vld   <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_data_vld   <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;
      if (frame_start) begin
        // Also the abort path: a frame in progress is dropped without status
        r_state    <= DATA;
        r_shift    <= '0;
        r_bitcnt   <= '0;
        r_run_par  <= 1'b0;
        r_par_flag <= 1'b0;
        r_stp_flag <= 1'b0;
        r_par_en   <= cfg_par_en;
        r_par_typ  <= par_typ_e'(cfg_par_typ);
        r_stop2    <= cfg_stop2;
        r_busy     <= 1'b1;
      end else if (bit_vld) begin
        case (r_state)
          DATA: begin
            r_shift   <= {sampled_bit, r_shift[DATA_WIDTH-1:1]};
            r_run_par <= r_run_par ^ sampled_bit;
            r_bitcnt  <= r_bitcnt + BITCNT_W'(1);
            if (w_last_data)
              r_state <= r_par_en ? PARITY : STOP1;
          end
          PARITY: begin
            if (sampled_bit != exp_parity(r_par_typ, r_run_par))
              r_par_flag <= 1'b1;
            r_state <= STOP1;
          end
          STOP1: begin
            if (r_stop2) begin
              if (!sampled_bit)
                r_stp_flag <= 1'b1;
              r_state <= STOP2;
            end
          end
          default: ;
        endcase
        if (w_finish) begin
          r_state      <= IDLE;
          r_busy       <= 1'b0;
          r_p_data     <= r_shift;
          r_frame_done <= 1'b1;
          r_par_err    <= r_par_flag;
          r_stp_err    <= w_stp_final;
          r_data_vld   <= ~(r_par_flag | w_stp_final);
        end
      end
    end
  end

  // Counters advance one cycle after frame_done, so a cnt_clr raised
  // alongside frame_done wins over that frame's increment
  sat_counter #(.CNT_W(CNT_W)) u_par_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (r_frame_done & r_par_err),
    .i_clr   (cnt_clr),
    .o_count (par_err_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_stp_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (r_frame_done & r_stp_err),
    .i_clr   (cnt_clr),
    .o_count (stp_err_cnt)
  );

  assign busy       = r_busy;
  assign p_data     = r_p_data;
  assign frame_done = r_frame_done;
  assign data_vld   = r_data_vld;
  assign par_err    = r_par_err;
  assign stp_err    = r_stp_err;

endmodule

// File: tb/tb_uart_rx_frame_checker.sv
// Randomised self-checking bench: an 8-bit/CNT_W=2 instance and a 5-bit
// instance share one stimulus bus; expectations come from frame-level rules.
`timescale 1ns/1ps
module tb_uart_rx_frame_checker;

  logic clk = 1'b0;
  logic rst, frame_start, bit_vld, sampled_bit, cfg_par_en, cfg_stop2, cnt_clr;
  logic [1:0] cfg_par_typ;

  logic       o8_busy, o8_frame_done, o8_data_vld, o8_par_err, o8_stp_err;
  logic [7:0] o8_p_data;
  logic [1:0] o8_par_cnt, o8_stp_cnt;
  logic       o5_busy, o5_frame_done, o5_data_vld, o5_par_err, o5_stp_err;
  logic [4:0] o5_p_data;
  logic [7:0] o5_par_cnt, o5_stp_cnt;

  int n_chk = 0;
  int n_fail = 0;
  int m_par_cnt = 0;
  int m_stp_cnt = 0;
  int fd8 = 0;
  int fd5 = 0;

  always #5 clk = ~clk;

  uart_rx_frame_checker #(.DATA_WIDTH(8), .CNT_W(2)) u_dut8 (
    .clk(clk), .rst(rst), .frame_start(frame_start), .bit_vld(bit_vld),
    .sampled_bit(sampled_bit), .cfg_par_en(cfg_par_en), .cfg_par_typ(cfg_par_typ),
    .cfg_stop2(cfg_stop2), .cnt_clr(cnt_clr), .busy(o8_busy), .p_data(o8_p_data),
    .frame_done(o8_frame_done), .data_vld(o8_data_vld), .par_err(o8_par_err),
    .stp_err(o8_stp_err), .par_err_cnt(o8_par_cnt), .stp_err_cnt(o8_stp_cnt)
  );

  uart_rx_frame_checker #(.DATA_WIDTH(5), .CNT_W(8)) u_dut5 (
    .clk(clk), .rst(rst), .frame_start(frame_start), .bit_vld(bit_vld),
    .sampled_bit(sampled_bit), .cfg_par_en(cfg_par_en), .cfg_par_typ(cfg_par_typ),
    .cfg_stop2(cfg_stop2), .cnt_clr(cnt_clr), .busy(o5_busy), .p_data(o5_p_data),
    .frame_done(o5_frame_done), .data_vld(o5_data_vld), .par_err(o5_par_err),
    .stp_err(o5_stp_err), .par_err_cnt(o5_par_cnt), .stp_err_cnt(o5_stp_cnt)
  );

  // Pulse tallies, read by the tasks #1 after a negedge
  always @(negedge clk) begin
    if (o8_frame_done) fd8 = fd8 + 1;
    if (o5_frame_done) fd5 = fd5 + 1;
  end

  // Reference: the parity bit a correct transmitter sends
  function automatic logic m_par_bit(input logic [8:0] d, input int n, input logic [1:0] typ);
    logic p;
    p = 1'b0;
    for (int i = 0; i < n; i++) p = p ^ d[i];
    case (typ)
      2'd0:    return p;
      2'd1:    return ~p;
      2'd2:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int m_sat(input int v, input int maxv);
    return (v + 1 > maxv) ? maxv : v + 1;
  endfunction

  // Drives one frame; returns at the negedge after the last bit strobe
  task automatic run_frame(input logic [8:0] d, input int n, input logic pen,
                           input logic [1:0] typ, input logic st2, input logic pbit,
                           input logic s1, input logic s2, input int unsigned maxgap,
                           input logic collide, input logic scramble);
    logic bq[$];
    @(negedge clk);
    frame_start = 1'b1; cfg_par_en = pen; cfg_par_typ = typ; cfg_stop2 = st2;
    bit_vld = collide; sampled_bit = 1'($urandom);
    @(negedge clk);
    frame_start = 1'b0; bit_vld = 1'b0;
    if (scramble) begin
      cfg_par_en = 1'($urandom); cfg_par_typ = 2'($urandom); cfg_stop2 = 1'($urandom);
    end
    for (int i = 0; i < n; i++) bq.push_back(d[i]);
    if (pen) bq.push_back(pbit);
    bq.push_back(s1);
    if (st2) bq.push_back(s2);
    foreach (bq[i]) begin
      repeat ($urandom_range(maxgap, 0)) @(negedge clk);
      bit_vld = 1'b1; sampled_bit = bq[i];
      @(negedge clk);
      bit_vld = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; frame_start = 0; bit_vld = 0; sampled_bit = 0;
    cfg_par_en = 0; cfg_par_typ = 0; cfg_stop2 = 0; cnt_clr = 0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({o8_busy, o8_p_data, o8_frame_done, o8_data_vld, o8_par_err, o8_stp_err,
         o8_par_cnt, o8_stp_cnt} !== '0) begin
      n_fail++; $display("FAIL reset_dut8: got busy=%b data=%h fd=%b", o8_busy, o8_p_data, o8_frame_done);
    end
    n_chk++;
    if ({o5_busy, o5_p_data, o5_frame_done, o5_data_vld, o5_par_err, o5_stp_err,
         o5_par_cnt, o5_stp_cnt} !== '0) begin
      n_fail++; $display("FAIL reset_dut5: got busy=%b data=%h fd=%b", o5_busy, o5_p_data, o5_frame_done);
    end
    rst = 1'b0;
    m_par_cnt = 0; m_stp_cnt = 0;
  endtask

  task automatic test_even_clean;
    run_frame(9'h0A5, 8, 1, 2'd0, 0, 1'b0, 1'b1, 1'b1, 0, 0, 0);
    n_chk++;
    if ({o8_frame_done, o8_data_vld, o8_par_err, o8_stp_err, o8_busy} !== 5'b11000) begin
      n_fail++; $display("FAIL even_status: got fd/vld/pe/se/busy=%b%b%b%b%b expected 11000",
        o8_frame_done, o8_data_vld, o8_par_err, o8_stp_err, o8_busy);
    end
    n_chk++;
    if (o8_p_data !== 8'hA5) begin
      n_fail++; $display("FAIL even_data: got %h expected a5", o8_p_data);
    end
    @(negedge clk);
    n_chk++;
    if ({o8_frame_done, o8_par_cnt, o8_stp_cnt} !== 5'b0) begin
      n_fail++; $display("FAIL even_after: got fd=%b pcnt=%0d scnt=%0d expected 0 0 0",
        o8_frame_done, o8_par_cnt, o8_stp_cnt);
    end
  endtask

  task automatic test_odd_err;
    run_frame(9'h0A5, 8, 1, 2'd1, 0, 1'b0, 1'b1, 1'b1, 1, 0, 0);
    n_chk++;
    if ({o8_frame_done, o8_data_vld, o8_par_err, o8_stp_err} !== 4'b1010 || o8_p_data !== 8'hA5) begin
      n_fail++; $display("FAIL odd_status: got fd/vld/pe/se=%b%b%b%b data=%h expected 1010 a5",
        o8_frame_done, o8_data_vld, o8_par_err, o8_stp_err, o8_p_data);
    end
    @(negedge clk);
    m_par_cnt = m_sat(m_par_cnt, 3);
    n_chk++;
    if (o8_par_cnt !== 2'(m_par_cnt)) begin
      n_fail++; $display("FAIL odd_cnt: got %0d expected %0d", o8_par_cnt, m_par_cnt);
    end
  endtask

  task automatic test_stop2_mark;
    run_frame(9'h03C, 8, 1, 2'd2, 1, 1'b1, 1'b1, 1'b0, 1, 0, 0);
    n_chk++;
    if ({o8_frame_done, o8_data_vld, o8_par_err, o8_stp_err} !== 4'b1001 || o8_p_data !== 8'h3C) begin
      n_fail++; $display("FAIL stop2_status: got fd/vld/pe/se=%b%b%b%b data=%h expected 1001 3c",
        o8_frame_done, o8_data_vld, o8_par_err, o8_stp_err, o8_p_data);
    end
    @(negedge clk);
    m_stp_cnt = m_sat(m_stp_cnt, 3);
    n_chk++;
    if (o8_stp_cnt !== 2'(m_stp_cnt) || o8_par_cnt !== 2'(m_par_cnt)) begin
      n_fail++; $display("FAIL stop2_cnt: got s=%0d p=%0d expected s=%0d p=%0d",
        o8_stp_cnt, o8_par_cnt, m_stp_cnt, m_par_cnt);
    end
  endtask

  task automatic test_saturate;
    @(negedge clk); cnt_clr = 1'b1;
    @(negedge clk); cnt_clr = 1'b0;
    m_par_cnt = 0; m_stp_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      run_frame(9'h0A5, 8, 1, 2'd1, 0, 1'b0, 1'b1, 1'b1, 1, 0, 0);
      @(negedge clk);
      m_par_cnt = m_sat(m_par_cnt, 3);
    end
    n_chk++;
    if (o8_par_cnt !== 2'd3 || m_par_cnt != 3) begin
      n_fail++; $display("FAIL sat_cnt: got %0d expected 3", o8_par_cnt);
    end
    run_frame(9'h0A5, 8, 1, 2'd1, 0, 1'b0, 1'b1, 1'b1, 1, 0, 0);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    m_par_cnt = 0; m_stp_cnt = 0;
    n_chk++;
    if (o8_par_cnt !== 2'd0) begin
      n_fail++; $display("FAIL sat_clr_priority: got %0d expected 0", o8_par_cnt);
    end
  endtask

  task automatic test_abort;
    int snap;
    @(negedge clk); #1 snap = fd8;
    frame_start = 1'b1; cfg_par_en = 1; cfg_par_typ = 2'd0; cfg_stop2 = 0;
    @(negedge clk); frame_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bit_vld = 1'b1; sampled_bit = 1'b0;
      @(negedge clk); bit_vld = 1'b0;
    end
    run_frame(9'h055, 8, 1, 2'd0, 0, 1'b0, 1'b1, 1'b1, 1, 0, 0);
    n_chk++;
    if (o8_frame_done !== 1'b1 || o8_data_vld !== 1'b1 || o8_p_data !== 8'h55) begin
      n_fail++; $display("FAIL abort_data: got fd=%b vld=%b data=%h expected 1 1 55",
        o8_frame_done, o8_data_vld, o8_p_data);
    end
    @(negedge clk); #1;
    n_chk++;
    if (fd8 - snap != 1 || o8_par_cnt !== 2'(m_par_cnt) || o8_stp_cnt !== 2'(m_stp_cnt)) begin
      n_fail++; $display("FAIL abort_count: got done_pulses=%0d p=%0d s=%0d expected 1 %0d %0d",
        fd8 - snap, o8_par_cnt, o8_stp_cnt, m_par_cnt, m_stp_cnt);
    end
  endtask

  task automatic test_random;
    logic [8:0] d;
    logic pen, st2, pbit, s1, s2, e_par, e_stp;
    logic [1:0] typ;
    for (int k = 0; k < 40; k++) begin
      d = {1'b0, 8'($urandom)};
      pen = 1'($urandom); typ = 2'($urandom); st2 = 1'($urandom);
      pbit = m_par_bit(d, 8, typ) ^ ($urandom_range(3, 0) == 0);
      s1 = ($urandom_range(4, 0) != 0);
      s2 = ($urandom_range(4, 0) != 0);
      e_par = pen && (pbit != m_par_bit(d, 8, typ));
      e_stp = !s1 || (st2 && !s2);
      run_frame(d, 8, pen, typ, st2, pbit, s1, s2, 2, 1'($urandom), 1'($urandom));
      n_chk++;
      if ({o8_frame_done, o8_busy, o8_par_err, o8_stp_err, o8_data_vld} !==
          {1'b1, 1'b0, e_par, e_stp, !(e_par || e_stp)} || o8_p_data !== d[7:0]) begin
        n_fail++; $display("FAIL rand_frame[%0d]: got fd/busy/pe/se/vld=%b%b%b%b%b data=%h expected 10%b%b%b data=%h",
          k, o8_frame_done, o8_busy, o8_par_err, o8_stp_err, o8_data_vld, o8_p_data,
          e_par, e_stp, !(e_par || e_stp), d[7:0]);
      end
      @(negedge clk);
      if (e_par) m_par_cnt = m_sat(m_par_cnt, 3);
      if (e_stp) m_stp_cnt = m_sat(m_stp_cnt, 3);
      n_chk++;
      if (o8_frame_done !== 1'b0 || o8_par_cnt !== 2'(m_par_cnt) || o8_stp_cnt !== 2'(m_stp_cnt)) begin
        n_fail++; $display("FAIL rand_cnt[%0d]: got fd=%b p=%0d s=%0d expected 0 %0d %0d",
          k, o8_frame_done, o8_par_cnt, o8_stp_cnt, m_par_cnt, m_stp_cnt);
      end
    end
  endtask

  task automatic test_width5;
    int snap;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    m_par_cnt = 0; m_stp_cnt = 0;
    run_frame(9'h013, 5, 0, 2'd0, 0, 1'b0, 1'b1, 1'b1, 0, 0, 0);
    n_chk++;
    if (o5_frame_done !== 1'b1 || o5_data_vld !== 1'b1 || o5_par_err !== 1'b0 || o5_p_data !== 5'h13) begin
      n_fail++; $display("FAIL w5_frame: got fd=%b vld=%b pe=%b data=%h expected 1 1 0 13",
        o5_frame_done, o5_data_vld, o5_par_err, o5_p_data);
    end
    @(negedge clk);
    n_chk++;
    if (o5_frame_done !== 1'b0 || o5_stp_cnt !== 8'd0) begin
      n_fail++; $display("FAIL w5_pulse: got fd=%b scnt=%0d expected 0 0", o5_frame_done, o5_stp_cnt);
    end
    // async reset partway through a frame
    frame_start = 1'b1; cfg_par_en = 0; cfg_stop2 = 0;
    @(negedge clk); frame_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bit_vld = 1'b1; sampled_bit = 1'b1;
      @(negedge clk); bit_vld = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (o5_busy !== 1'b0 || o5_p_data !== 5'h0) begin
      n_fail++; $display("FAIL w5_async_rst: got busy=%b data=%h expected 0 00", o5_busy, o5_p_data);
    end
    @(negedge clk); rst = 1'b0;
    #1 snap = fd5;
    for (int i = 0; i < 3; i++) begin
      bit_vld = 1'b1; sampled_bit = 1'b1;
      @(negedge clk); bit_vld = 1'b0;
    end
    @(negedge clk); #1;
    n_chk++;
    if (fd5 != snap || o5_busy !== 1'b0) begin
      n_fail++; $display("FAIL w5_no_done: got pulses=%0d busy=%b expected 0 0", fd5 - snap, o5_busy);
    end
  endtask

  initial begin
    test_reset();
    test_even_clean();
    test_odd_err();
    test_stop2_mark();
    test_saturate();
    test_abort();
    test_random();
    test_width5();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_checker.md
Name: uart_rx_frame_checker

Overview:
Parametrised successor to the UART RX parity checker. Consumes oversampled-and-voted bits from the RX sampler, deserialises a configurable-width data field and checks parity (even/odd/mark/space/none) and 1 or 2 stop bits. Reports per-frame status and keeps saturating error counters. Sits between the RX edge/bit sampler and the RX FSM/SYS_CTRL data sink.

Parameters:
DATA_WIDTH, 8, data bits per frame; legal range 5..9; LSB received first.
CNT_W, 8, width of each saturating error counter.

Ports:
clk  in  1  system clock (UART RX clock domain)
rst  in  1  asynchronous, active-high reset
frame_start  in  1  one-cycle pulse: start bit validated by sampler
bit_vld  in  1  one-cycle strobe: sampled_bit holds a new voted bit
sampled_bit  in  1  voted RX bit value
cfg_par_en  in  1  1: frame carries a parity bit
cfg_par_typ  in  2  00 even, 01 odd, 10 mark, 11 space
cfg_stop2  in  1  1: two stop bits expected
cnt_clr  in  1  synchronous clear of both error counters
busy  out  1  frame in progress
p_data  out  DATA_WIDTH  received data, held until next frame_done
frame_done  out  1  one-cycle pulse after last stop bit
data_vld  out  1  frame_done AND no parity error AND no stop error
par_err  out  1  parity mismatch of finished frame, valid with frame_done
stp_err  out  1  any stop bit sampled 0, valid with frame_done
par_err_cnt  out  CNT_W  saturating count of parity errors
stp_err_cnt  out  CNT_W  saturating count of stop errors

Behaviour:
- Reset: state IDLE; busy, p_data, frame_done, data_vld, par_err, stp_err, both counters = 0.
- cfg_* captured into shadow registers on frame_start; changes mid-frame have no effect.
- States: IDLE, DATA, PARITY, STOP1, STOP2.
- IDLE: bit_vld ignored. frame_start -> DATA; clear shift reg, bit counter, running parity, error flags.
- DATA: each bit_vld shifts sampled_bit in at MSB (right shift, LSB-first) and XORs it into running parity. After the DATA_WIDTH-th bit -> PARITY if par_en, else STOP1.
- PARITY: expected bit = even: running parity; odd: ~running parity; mark: 1; space: 0. Mismatch sets internal par flag. -> STOP1.
- STOP1: bit 0 sets stop flag; -> STOP2 if stop2, else finish.
- STOP2: bit 0 sets stop flag; finish.
- Finish: state -> IDLE in the cycle after the last bit_vld. frame_done, par_err, stp_err and data_vld are registered, pulse for exactly that one cycle. p_data updates the same cycle and is held.
- Parity with cfg_par_en=0: par_err always 0.
- Counters: +1 on frame_done with the respective error; saturate at all-ones, no wrap. cnt_clr takes priority over a simultaneous increment.
- busy = 1 from the cycle after frame_start until the finish cycle inclusive-exclusive (0 in the frame_done cycle).
- frame_start while busy: abort current frame silently (no frame_done, no counter update) and restart in DATA.
- frame_start and bit_vld in the same cycle: frame_start wins; that bit is discarded.
- Async reset mid-frame: immediate return to IDLE, all outputs 0, counters cleared.
- Max frame: 1+9+1+2 = 13 bits; bit counter 4 bits.

Decomposition:
- Package uart_pkg: parity-type encodings (PAR_EVEN, PAR_ODD, PAR_MARK, PAR_SPACE), FSM state enum, and DATA_WIDTH legal-range constants.
- Sub-module sat_counter (param CNT_W; inc, clr, count), instantiated twice for the two error counters.

Test Plan:
- DATA_WIDTH=8, even parity, 1 stop: bits of 0xA5, parity 0, stop 1 -> frame_done=1, data_vld=1, p_data=0xA5, par_err=0, counters 0.
- Odd parity, 0xA5 with parity bit 0 -> par_err=1, data_vld=0, par_err_cnt=1; p_data=0xA5.
- stop2=1, mark parity: 0x3C, parity 1, stop bits 1,0 -> stp_err=1, par_err=0, stp_err_cnt=1.
- CNT_W=2: 5 consecutive parity-error frames -> par_err_cnt=3 (saturated). cnt_clr asserted together with the 6th error frame_done -> counter 0.
- frame_start after 4 data bits, then a clean 0x55 frame -> exactly one frame_done, p_data=0x55, no counter change.
- DATA_WIDTH=5, par_en=0: bits of 0x13, stop 1 -> frame_done 1 cycle after the stop strobe, p_data=0x13. Async rst pulse mid-frame -> busy=0, no frame_done.
